// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// irq_controller_if : config bus and pipeline handshake of irq_controller
// Revision: 1.0
// ============================================================================
interface irq_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) ();
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [31:0]     cfg_rdata;
  logic            irq_req;
  logic [31:0]     irq_vec;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;
  logic [31:0]     ack_pc;
  logic            irq_ret;
  logic [31:0]     epc;
  logic            in_service;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack, ack_pc, irq_ret,
    input  cfg_rdata, irq_req, irq_vec, irq_id, epc, in_service
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack, ack_pc, irq_ret,
    output cfg_rdata, irq_req, irq_vec, irq_id, epc, in_service
  );
endinterface
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// irq_controller : synchronised, masked, fixed-priority interrupt controller
// Revision: 1.0
// ============================================================================
module irq_controller #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 4,
  parameter int          ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_controller_if.slave    bus
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_req     = 2'd1;
  localparam logic [1:0] c_st_service = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_pend;
  logic               r_gie;
  logic [ID_W-1:0]    r_id;
  logic [31:0]        r_epc;

  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_ack_clr;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [ID_W-1:0]    w_win;
  logic [31:0]        w_rdata;

  assign w_elig = r_pend & r_mask & {NUM_IRQ{r_gie}};
  assign w_rise = r_sync & ~r_prev;
  assign w_w1c  = (bus.cfg_we && bus.cfg_addr == 2'd2) ? bus.cfg_wdata[NUM_IRQ-1:0]
                                                        : '0;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  always_comb begin
    w_ack_clr = '0;
    if (r_state == c_st_req && bus.irq_ack) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (r_id == ID_W'(i)) w_ack_clr[i] = 1'b1;
      end
    end
  end

  // Edge lines: a new rising edge beats a simultaneous clear. Level lines follow sync.
  assign w_pend_nxt = (r_mode & ((r_pend & ~(w_w1c | w_ack_clr)) | w_rise))
                    | (~r_mode & r_sync);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync  <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync  <= r_sync1;
      r_prev  <= r_sync;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_mode <= '1;
      r_gie  <= 1'b0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0:    r_mask <= bus.cfg_wdata[NUM_IRQ-1:0];
        2'd1:    r_mode <= bus.cfg_wdata[NUM_IRQ-1:0];
        2'd3:    r_gie  <= bus.cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // irq_id only moves when leaving IDLE, so the request stays committed in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_id    <= '0;
      r_epc   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (|w_elig) begin
            r_state <= c_st_req;
            r_id    <= w_win;
          end
        end
        c_st_req: begin
          if (bus.irq_ack) begin
            r_state <= c_st_service;
            r_epc   <= bus.ack_pc;
          end
        end
        c_st_service: begin
          if (bus.irq_ret) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.cfg_addr)
      2'd0:    w_rdata[NUM_IRQ-1:0] = r_mask;
      2'd1:    w_rdata[NUM_IRQ-1:0] = r_mode;
      2'd2:    w_rdata[NUM_IRQ-1:0] = r_pend;
      default: w_rdata[0]           = r_gie;
    endcase
  end

  assign bus.cfg_rdata  = w_rdata;
  assign bus.irq_req    = (r_state == c_st_req);
  assign bus.in_service = (r_state == c_st_service);
  assign bus.irq_id     = r_id;
  assign bus.irq_vec    = VEC_BASE + 32'(r_id) * 32'(VEC_STRIDE);
  assign bus.epc        = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// tb_irq_controller : register table, directed corner sequences, random vs model
// Revision: 1.0
// ============================================================================
module tb_irq_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_in = '0;
  int           n_checks = 0;
  int           n_fail = 0;

  irq_controller_if #(.NUM_IRQ(N), .ID_W(3)) bus ();

  irq_controller #(.NUM_IRQ(N), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(4), .ID_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[12];

  // Reference model state: per-line arrays plus a queue of past irq_in samples.
  bit       m_mask[N], m_mode[N], m_pend[N];
  bit       m_gie;
  int       m_phase;   // 0 idle, 1 requesting, 2 servicing
  int       m_id;
  bit [31:0] m_epc;
  bit [N-1:0] hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic pulse_irq(input logic [N-1:0] m);
    irq_in = irq_in | m;
    @(negedge clk);
    irq_in = irq_in & ~m;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    bus.irq_ack = 1'b1; bus.ack_pc = pc;
    @(negedge clk);
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_ret();
    bus.irq_ret = 1'b1;
    @(negedge clk);
    bus.irq_ret = 1'b0;
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!bus.irq_req && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req", 32'(bus.irq_req), 32'd1);
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) begin
      case (a)
        2'd0: r[i] = m_mask[i];
        2'd1: r[i] = m_mode[i];
        2'd2: r[i] = m_pend[i];
        default: ;
      endcase
    end
    if (a == 2'd3) r[0] = m_gie;
    return r;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_mask[i] = 0; m_mode[i] = 1; m_pend[i] = 0;
    end
    m_gie = 0; m_phase = 0; m_id = 0; m_epc = 0;
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back('0);
  endfunction

  // One clock of the specified behaviour, using the inputs present at the edge.
  function automatic void m_step();
    bit       np[N];
    int       win = -1;
    bit [N-1:0] sync_v = hist[1];
    bit [N-1:0] prev_v = hist[2];
    for (int i = 0; i < N; i++)
      if (win < 0 && m_pend[i] && m_mask[i] && m_gie) win = i;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        bit clr = (bus.cfg_we && bus.cfg_addr == 2'd2 && bus.cfg_wdata[i])
               || (m_phase == 1 && bus.irq_ack && m_id == i);
        if (sync_v[i] && !prev_v[i]) np[i] = 1;
        else if (clr)                np[i] = 0;
        else                         np[i] = m_pend[i];
      end else begin
        np[i] = sync_v[i];
      end
    end
    case (m_phase)
      0: if (win >= 0) begin m_phase = 1; m_id = win; end
      1: if (bus.irq_ack) begin m_phase = 2; m_epc = bus.ack_pc; end
      default: if (bus.irq_ret) m_phase = 0;
    endcase
    m_pend = np;
    if (bus.cfg_we) begin
      for (int i = 0; i < N; i++) begin
        if (bus.cfg_addr == 2'd0) m_mask[i] = bus.cfg_wdata[i];
        if (bus.cfg_addr == 2'd1) m_mode[i] = bus.cfg_wdata[i];
      end
      if (bus.cfg_addr == 2'd3) m_gie = bus.cfg_wdata[0];
    end
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endfunction

  initial begin
    logic [31:0] d;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.irq_ack = 0; bus.ack_pc = 0; bus.irq_ret = 0;

    tv[0]  = '{1'b0, 2'd0, 32'h0,         32'h0};
    tv[1]  = '{1'b0, 2'd1, 32'h0,         32'hFF};
    tv[2]  = '{1'b0, 2'd2, 32'h0,         32'h0};
    tv[3]  = '{1'b0, 2'd3, 32'h0,         32'h0};
    tv[4]  = '{1'b1, 2'd0, 32'hFFFF_FFA5, 32'hA5};
    tv[5]  = '{1'b1, 2'd1, 32'h1234_5600, 32'h0};
    tv[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFE, 32'h0};
    tv[7]  = '{1'b1, 2'd3, 32'h0000_0003, 32'h1};
    tv[8]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
    tv[9]  = '{1'b1, 2'd1, 32'h0000_00FF, 32'hFF};
    tv[10] = '{1'b1, 2'd0, 32'h0,         32'h0};
    tv[11] = '{1'b1, 2'd3, 32'h0,         32'h0};

    repeat (2) @(negedge clk);
    chk("rst_irq_req", 32'(bus.irq_req), 0);
    chk("rst_in_service", 32'(bus.in_service), 0);
    chk("rst_epc", bus.epc, 0);
    chk("rst_irq_id", 32'(bus.irq_id), 0);
    chk("rst_irq_vec", bus.irq_vec, 32'h100);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      bus.cfg_we = tv[i].we; bus.cfg_addr = tv[i].addr; bus.cfg_wdata = tv[i].wdata;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      #1;
      chk($sformatf("reg_vec%0d", i), bus.cfg_rdata, tv[i].exp);
    end
    @(negedge clk);

    // Single edge on line 3: exact latency, vector, ack.
    cfg_wr(2'd0, 32'hFF);
    cfg_wr(2'd3, 32'h1);
    pulse_irq(8'h08);
    repeat (2) @(negedge clk);
    chk("lat_no_req_yet", 32'(bus.irq_req), 0);
    rd(2'd2, d);
    chk("lat_pend3", d, 32'h08);
    @(negedge clk);
    chk("lat_req", 32'(bus.irq_req), 1);
    chk("lat_id", 32'(bus.irq_id), 3);
    chk("lat_vec", bus.irq_vec, 32'h10C);
    do_ack(32'h40);
    chk("ack_epc", bus.epc, 32'h40);
    chk("ack_in_service", 32'(bus.in_service), 1);
    rd(2'd2, d);
    chk("ack_pend_clr", d, 0);
    do_ret();
    chk("ret_idle", 32'(bus.in_service), 0);

    // Lines 5 and 2 together: 2 first, 5 one cycle after return.
    pulse_irq(8'h24);
    wait_req(10);
    chk("prio_first", 32'(bus.irq_id), 2);
    do_ack(32'h80);
    do_ret();
    chk("prio_idle_gap", 32'(bus.irq_req), 0);
    @(negedge clk);
    chk("prio_second_req", 32'(bus.irq_req), 1);
    chk("prio_second_id", 32'(bus.irq_id), 5);
    chk("prio_second_vec", bus.irq_vec, 32'h114);
    do_ack(32'h84);
    do_ret();

    // No nesting: line 0 pends while line 7 is serviced.
    pulse_irq(8'h80);
    wait_req(10);
    chk("nest_id7", 32'(bus.irq_id), 7);
    do_ack(32'h90);
    pulse_irq(8'h01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("nest_no_req", 32'(bus.irq_req), 0);
    end
    rd(2'd2, d);
    chk("nest_pend0", d, 32'h01);
    do_ret();
    chk("nest_ret_idle", 32'(bus.irq_req | bus.in_service), 0);
    @(negedge clk);
    chk("nest_req0", 32'(bus.irq_req), 1);
    chk("nest_id0", 32'(bus.irq_id), 0);
    do_ack(32'hA0);
    do_ret();

    // Level line 1: re-requests while held, W1C ignored.
    cfg_wr(2'd1, 32'hFD);
    irq_in[1] = 1'b1;
    wait_req(10);
    chk("lvl_id", 32'(bus.irq_id), 1);
    do_ack(32'hB0);
    cfg_wr(2'd2, 32'h02);
    rd(2'd2, d);
    chk("lvl_w1c_ignored", d, 32'h02);
    do_ret();
    chk("lvl_idle", 32'(bus.irq_req), 0);
    @(negedge clk);
    chk("lvl_rereq", 32'(bus.irq_req), 1);
    chk("lvl_rereq_id", 32'(bus.irq_id), 1);
    do_ack(32'hB4);
    irq_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    rd(2'd2, d);
    chk("lvl_pend_follows", d, 0);
    do_ret();
    repeat (5) @(negedge clk);
    chk("lvl_no_more", 32'(bus.irq_req | bus.in_service), 0);
    cfg_wr(2'd1, 32'hFF);

    // Committed request survives MASK=0 and GIE=0.
    pulse_irq(8'h10);
    wait_req(10);
    cfg_wr(2'd0, 32'h0);
    cfg_wr(2'd3, 32'h0);
    chk("commit_req", 32'(bus.irq_req), 1);
    chk("commit_id", 32'(bus.irq_id), 4);
    chk("commit_vec", bus.irq_vec, 32'h110);
    do_ack(32'hC0);
    do_ret();
    pulse_irq(8'h40);
    repeat (4) @(negedge clk);
    rd(2'd2, d);
    chk("w1c_pend6", d, 32'h40);
    cfg_wr(2'd2, 32'h40);
    rd(2'd2, d);
    chk("w1c_cleared", d, 0);
    cfg_wr(2'd0, 32'hFF);
    cfg_wr(2'd3, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("w1c_never_req", 32'(bus.irq_req), 0);
    end

    // Asynchronous reset during SERVICE.
    pulse_irq(8'h04);
    wait_req(10);
    do_ack(32'h1234);
    chk("svc_before_rst", 32'(bus.in_service), 1);
    bus.cfg_addr = 2'd0;
    #2 rst = 1'b1;
    #1;
    chk("arst_in_service", 32'(bus.in_service), 0);
    chk("arst_irq_req", 32'(bus.irq_req), 0);
    chk("arst_epc", bus.epc, 0);
    chk("arst_mask", bus.cfg_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_irq(8'h08);
    repeat (6) @(negedge clk);
    chk("post_rst_no_req", 32'(bus.irq_req), 0);
    cfg_wr(2'd0, 32'hFF);
    cfg_wr(2'd3, 32'h1);
    wait_req(6);
    chk("post_rst_id", 32'(bus.irq_id), 3);
    do_ack(32'h0);
    do_ret();

    // Randomised run against the reference model.
    irq_in = '0;
    rst = 1'b1;
    @(negedge clk);
    m_reset();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
      bus.cfg_we    = ($urandom_range(5) == 0);
      bus.cfg_addr  = 2'($urandom_range(3));
      bus.cfg_wdata = $urandom;
      if (bus.cfg_addr == 2'd3) bus.cfg_wdata[0] = ($urandom_range(3) != 0);
      bus.irq_ack   = ($urandom_range(2) == 0);
      bus.ack_pc    = $urandom;
      bus.irq_ret   = ($urandom_range(3) == 0);
      @(posedge clk);
      m_step();
      #1;
      chk("rnd_irq_req", 32'(bus.irq_req), 32'(m_phase == 1));
      chk("rnd_in_service", 32'(bus.in_service), 32'(m_phase == 2));
      chk("rnd_irq_id", 32'(bus.irq_id), 32'(m_id));
      chk("rnd_irq_vec", bus.irq_vec, 32'h100 + 32'(m_id) * 4);
      chk("rnd_epc", bus.epc, m_epc);
      chk("rnd_rdata", bus.cfg_rdata, m_read(bus.cfg_addr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout no_finish actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised multi-channel successor to the single-line external interrupt handler in the 5-stage RISC-V core.
- Synchronises NUM_IRQ asynchronous request lines and latches them per channel in edge or level mode.
- Applies a per-channel mask and a global enable, picks the highest-priority line, and drives a request/acknowledge handshake with hazard_detection and fetch.
- Saves the return PC, and blocks nesting until the handler executes a return.

Parameters:
- NUM_IRQ, 8, number of interrupt lines (1..32)
- VEC_BASE, 32'h0000_0100, handler address of line 0
- VEC_STRIDE, 4, byte spacing between handler entry points
- ID_W, $clog2(NUM_IRQ) (min 1), width of the line index

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- irq_in  in  NUM_IRQ  raw asynchronous interrupt lines
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  register select: 0=MASK, 1=MODE, 2=PEND (W1C), 3=CTRL (bit0=GIE)
- cfg_wdata  in  32  write data; bits above NUM_IRQ-1 are ignored
- cfg_rdata  out  32  combinational read of the register at cfg_addr; unused bits read 0
- irq_req  out  1  interrupt request to hazard unit (flush + redirect)
- irq_vec  out  32  handler address, VEC_BASE + irq_id*VEC_STRIDE
- irq_id  out  ID_W  index of the line being requested/serviced
- irq_ack  in  1  pipeline has flushed and redirected PC to irq_vec
- ack_pc  in  32  return PC captured with irq_ack
- irq_ret  in  1  one-cycle pulse: handler return executed in EXE
- epc  out  32  saved return PC
- in_service  out  1  high while a handler is running

Behaviour:
- Reset values (asynchronous): state=IDLE; MASK=0; MODE=all 1 (edge); PEND=0; GIE=0; synchroniser and previous-value flops=0; epc=0; irq_id=0; irq_req=0; in_service=0. irq_vec therefore resets to VEC_BASE.
- Synchroniser: 2 flops per line, giving sync[i].
- Edge mode (MODE[i]=1):
  - PEND[i] sets on the cycle where sync[i]=1 and prev[i]=0.
  - PEND[i] clears on W1C or on irq_ack for line i.
  - If set and clear coincide, set wins.
- Level mode (MODE[i]=0): PEND[i] = sync[i] each cycle; W1C and ack have no effect.
- Eligible lines: elig = PEND & MASK, gated by GIE.
- Priority: the lowest index wins; this is a fixed priority scheme.
- States:
  - IDLE:
    - If elig != 0, next state is REQ and irq_id latches the winner.
    - irq_req=0 and in_service=0.
  - REQ:
    - irq_req=1.
    - irq_id and irq_vec are held stable regardless of later MASK, GIE or PEND changes; the request is committed.
    - On irq_ack: epc<=ack_pc, clear PEND[irq_id] if edge mode, next state SERVICE.
    - irq_ret is ignored in this state.
  - SERVICE:
    - in_service=1 and irq_req=0.
    - New pending lines accumulate but are not requested, so there is no nesting.
    - On irq_ret, next state is IDLE.
    - irq_ack is ignored in this state.
- Latency: an edge on irq_in first sampled at edge k sets PEND at k+2 and state=REQ at k+3. irq_req is therefore visible after edge k+3.
- irq_ret with an eligible line in the same cycle: go to IDLE first; the new request follows one cycle later. A retained edge pend is never lost.
- Config writes take effect at the next clock edge.
- A write to PEND acts as W1C on edge-mode bits only. A PEND write in the same cycle as irq_ack clears the union of both.
- A level-mode line that is still asserted after return re-requests. This is intended; software must clear the source.
- Reset mid-REQ or mid-SERVICE returns to IDLE immediately, with all outputs at their reset values.

Test Plan:
- Reset, then MASK=0xFF, GIE=1, pulse irq_in[3] for 1 cycle:
  - irq_req rises 4 cycles after the pulse, with irq_id=3 and irq_vec=0x10C.
  - irq_ack with ack_pc=0x40 gives epc=0x40, in_service=1, PEND[3]=0.
- Lines 5 and 2 both rise in the same cycle:
  - First request is id=2.
  - After irq_ret, id=5 is requested one cycle later.
- In SERVICE, pulse irq_in[0]:
  - No irq_req while in_service=1.
  - irq_ret → IDLE, then REQ with id=0.
- MODE[1]=0 (level), hold irq_in[1]=1:
  - Request with id=1.
  - After ack+ret with the line still high, it re-requests.
  - Deassert the line → no further request; a W1C to bit 1 has no effect.
- Commitment and W1C:
  - While in REQ for id=4, write MASK=0 and GIE=0 → irq_req stays 1 and id stays 4.
  - Separately, a pending edge on line 6 cleared via PEND write 0x40 → never requested.
- Assert rst while in SERVICE:
  - Asynchronously in_service=0, irq_req=0, epc=0, MASK=0.
  - An edge arriving after reset release is not requested until MASK and GIE are written.
